// File: rtl/bit_count_arbiter.sv
// bit_count_arbiter: round-robin front end that shares one registered
// population-count unit among NUM_REQ requesters. One operation takes three
// cycles: grant/latch in IDLE, write-enable pulse in ISSUE, result capture
// in CAPTURE, followed by a one-cycle Ack to the winner.

module bit_count_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned INPUT_WIDTH = 10,
    parameter int unsigned COUNT_WIDTH = 4
) (
    input  logic                           CLK,
    input  logic                           RSTn,
    input  logic [NUM_REQ-1:0]             Req,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] ReqData,
    output logic [NUM_REQ-1:0]             Ack,
    output logic [COUNT_WIDTH-1:0]         Result,
    output logic                           Busy,
    output logic                           BcWrEn,
    output logic [INPUT_WIDTH-1:0]         BcInput,
    input  logic [COUNT_WIDTH-1:0]         BcCount
);

    localparam int unsigned PtrWidth = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StCapture = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PtrWidth-1:0]    ptr_q, ptr_d;
    logic [PtrWidth-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [COUNT_WIDTH-1:0] result_q, result_d;
    logic [INPUT_WIDTH-1:0] bc_input_q, bc_input_d;

    logic [NUM_REQ-1:0]     eligible;
    logic                   pick_valid;
    logic [PtrWidth-1:0]    pick_idx;
    logic [PtrWidth-1:0]    cand_idx;
    int unsigned            cand;

    // Round-robin search: first eligible requester at or above ptr, wrapping.
    // The requester being acked this cycle is masked so a held Req is not
    // mistaken for a fresh request.
    always_comb begin
        eligible   = Req & ~ack_q;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PtrWidth'(cand);
            if (!pick_valid && eligible[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed three-step sequence once a grant is made.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (pick_valid) state_d = StIssue;
            StIssue:   state_d = StCapture;
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        BcWrEn = (state_q == StIssue);
        Busy   = (state_q != StIdle);
    end

    // Datapath next values: latch the winner's word at grant, capture the
    // counter output only in CAPTURE (it is unreset and meaningless otherwise).
    always_comb begin
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        bc_input_d = bc_input_q;
        result_d   = result_q;
        ack_d      = '0;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d      = pick_idx;
                    bc_input_d = ReqData[32'(pick_idx)*INPUT_WIDTH +: INPUT_WIDTH];
                end
            end
            StCapture: begin
                result_d     = BcCount;
                ack_d[gnt_q] = 1'b1;
                if (gnt_q == PtrWidth'(NUM_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = gnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            ptr_q      <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            result_q   <= '0;
            bc_input_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            result_q   <= result_d;
            bc_input_q <= bc_input_d;
        end
    end

    assign Ack     = ack_q;
    assign Result  = result_q;
    assign BcInput = bc_input_q;

endmodule

// File: tb/tb_bit_count_arbiter.sv
// Directed bench for bit_count_arbiter with a behavioural registered
// population counter attached to the Bc* ports.

module tb_bit_count_arbiter;

    localparam int N = 4;
    localparam int W = 10;
    localparam int C = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic [C-1:0]   result;
    logic           busy;
    logic           bc_wr_en;
    logic [W-1:0]   bc_input;
    logic [C-1:0]   bc_count;

    int n_vec;
    int n_err;

    bit_count_arbiter #(
        .NUM_REQ    (N),
        .INPUT_WIDTH(W),
        .COUNT_WIDTH(C)
    ) dut (
        .CLK    (clk),
        .RSTn   (rst_n),
        .Req    (req),
        .ReqData(req_data),
        .Ack    (ack),
        .Result (result),
        .Busy   (busy),
        .BcWrEn (bc_wr_en),
        .BcInput(bc_input),
        .BcCount(bc_count)
    );

    // Counter model: registered ones count, one-cycle latency, no reset.
    always_ff @(posedge clk) begin
        if (bc_wr_en) bc_count <= C'($countones(bc_input));
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        tick();
        tick();
        n_vec++; if (ack !== 4'b0000) begin n_err++;
            $display("FAIL reset_ack got %b want 0000", ack); end
        n_vec++; if (result !== 4'd0) begin n_err++;
            $display("FAIL reset_result got %0d want 0", result); end
        n_vec++; if (busy !== 1'b0 || bc_wr_en !== 1'b0) begin n_err++;
            $display("FAIL reset_busy_wren got %b%b want 00", busy, bc_wr_en); end
        n_vec++; if (bc_input !== 10'd0) begin n_err++;
            $display("FAIL reset_bc_input got %b want 0", bc_input); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        req_data[0*W +: W] = 10'b1011001110;
        req = 4'b0001;
        tick();  // grant edge E0
        n_vec++; if (bc_wr_en !== 1'b1 || busy !== 1'b1 || ack !== 4'b0) begin n_err++;
            $display("FAIL single_issue got wren=%b busy=%b ack=%b want 1 1 0000",
                     bc_wr_en, busy, ack); end
        n_vec++; if (bc_input !== 10'b1011001110) begin n_err++;
            $display("FAIL single_bc_input got %b want 1011001110", bc_input); end
        tick();  // E1: CAPTURE
        n_vec++; if (bc_wr_en !== 1'b0 || busy !== 1'b1 || ack !== 4'b0) begin n_err++;
            $display("FAIL single_capture got wren=%b busy=%b ack=%b want 0 1 0000",
                     bc_wr_en, busy, ack); end
        tick();  // E2: Ack cycle
        n_vec++; if (ack !== 4'b0001) begin n_err++;
            $display("FAIL single_ack got %b want 0001", ack); end
        n_vec++; if (result !== 4'd6) begin n_err++;
            $display("FAIL single_result got %0d want 6", result); end
        n_vec++; if (busy !== 1'b0 || bc_wr_en !== 1'b0) begin n_err++;
            $display("FAIL single_ack_busy got busy=%b wren=%b want 0 0", busy, bc_wr_en); end
        req = 4'b0000;
        tick();
        n_vec++; if (ack !== 4'b0000 || result !== 4'd6 || busy !== 1'b0) begin n_err++;
            $display("FAIL single_after got ack=%b result=%0d busy=%b want 0000 6 0",
                     ack, result, busy); end
    endtask

    task automatic test_all_requesters();
        logic [C-1:0] exp_cnt [N];
        logic [N-1:0] exp_ack;
        apply_reset();
        req_data[0*W +: W] = 10'b0000000001;
        req_data[1*W +: W] = 10'b0000000111;
        req_data[2*W +: W] = 10'b0001111111;
        req_data[3*W +: W] = 10'b1111111111;
        exp_cnt[0] = 4'd1; exp_cnt[1] = 4'd3; exp_cnt[2] = 4'd7; exp_cnt[3] = 4'd10;
        req = 4'b1111;
        for (int op = 0; op < 8; op++) begin
            exp_ack = '0;
            exp_ack[op % N] = 1'b1;
            tick();
            n_vec++; if (bc_wr_en !== 1'b1) begin n_err++;
                $display("FAIL rr_issue op%0d got wren=%b want 1", op, bc_wr_en); end
            tick();
            tick();
            n_vec++; if (ack !== exp_ack || result !== exp_cnt[op % N]) begin n_err++;
                $display("FAIL rr_ack op%0d got ack=%b result=%0d want %b %0d",
                         op, ack, result, exp_ack, exp_cnt[op % N]); end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_boundary_words();
        apply_reset();
        req_data[0*W +: W] = 10'b0000000000;
        req = 4'b0001;
        tick(); tick(); tick();
        n_vec++; if (ack !== 4'b0001 || result !== 4'd0) begin n_err++;
            $display("FAIL zero_word got ack=%b result=%0d want 0001 0", ack, result); end
        req_data[1*W +: W] = 10'b1111111111;
        req = 4'b0010;
        tick(); tick(); tick();
        n_vec++; if (ack !== 4'b0010 || result !== 4'd10) begin n_err++;
            $display("FAIL ones_word got ack=%b result=%0d want 0010 10", ack, result); end
        req_data[0*W +: W] = 10'b0000000011;
        req = 4'b0001;
        tick();  // grant; now in ISSUE
        req_data[0*W +: W] = 10'b1111111111;
        tick();
        n_vec++; if (bc_input !== 10'b0000000011) begin n_err++;
            $display("FAIL held_input got %b want 0000000011", bc_input); end
        tick();
        n_vec++; if (ack !== 4'b0001 || result !== 4'd2) begin n_err++;
            $display("FAIL late_data got ack=%b result=%0d want 0001 2", ack, result); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        req_data[0*W +: W] = 10'b0000000011;
        req_data[3*W +: W] = 10'b1010101010;
        req = 4'b1000;
        tick(); tick(); tick();
        n_vec++; if (ack !== 4'b1000 || result !== 4'd5) begin n_err++;
            $display("FAIL wrap_first got ack=%b result=%0d want 1000 5", ack, result); end
        req = 4'b1001;
        tick(); tick(); tick();
        n_vec++; if (ack !== 4'b0001 || result !== 4'd2) begin n_err++;
            $display("FAIL wrap_second got ack=%b result=%0d want 0001 2", ack, result); end
        tick(); tick(); tick();
        n_vec++; if (ack !== 4'b1000 || result !== 4'd5) begin n_err++;
            $display("FAIL wrap_third got ack=%b result=%0d want 1000 5", ack, result); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_drop_and_regrant();
        apply_reset();
        req_data[2*W +: W] = 10'b1110000000;
        req = 4'b0100;
        tick();  // ISSUE
        req = 4'b0000;
        tick(); tick();
        n_vec++; if (ack !== 4'b0100 || result !== 4'd3) begin n_err++;
            $display("FAIL drop_ack got ack=%b result=%0d want 0100 3", ack, result); end
        req = 4'b0100;
        tick();  // edge ending Ack cycle: held Req is masked
        n_vec++; if (busy !== 1'b0 || bc_wr_en !== 1'b0) begin n_err++;
            $display("FAIL no_early_regrant got busy=%b wren=%b want 0 0", busy, bc_wr_en); end
        tick();
        n_vec++; if (busy !== 1'b1 || bc_wr_en !== 1'b1) begin n_err++;
            $display("FAIL regrant got busy=%b wren=%b want 1 1", busy, bc_wr_en); end
        tick(); tick();
        n_vec++; if (ack !== 4'b0100 || result !== 4'd3) begin n_err++;
            $display("FAIL regrant_ack got ack=%b result=%0d want 0100 3", ack, result); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        req_data[1*W +: W] = 10'b0000011111;
        req_data[2*W +: W] = 10'b1110000000;
        req_data[3*W +: W] = 10'b1100000000;
        req = 4'b0010;
        tick(); tick(); tick();
        n_vec++; if (ack !== 4'b0010 || result !== 4'd5) begin n_err++;
            $display("FAIL pre_reset_op got ack=%b result=%0d want 0010 5", ack, result); end
        req = 4'b1000;
        tick(); tick();  // now in CAPTURE for requester 3
        n_vec++; if (busy !== 1'b1 || bc_wr_en !== 1'b0) begin n_err++;
            $display("FAIL in_capture got busy=%b wren=%b want 1 0", busy, bc_wr_en); end
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        n_vec++; if (ack !== 4'b0000 || result !== 4'd0) begin n_err++;
            $display("FAIL abort_ack got ack=%b result=%0d want 0000 0", ack, result); end
        n_vec++; if (busy !== 1'b0 || bc_wr_en !== 1'b0 || bc_input !== 10'd0) begin n_err++;
            $display("FAIL abort_state got busy=%b wren=%b in=%b want 0 0 0",
                     busy, bc_wr_en, bc_input); end
        rst_n = 1'b1;
        req   = 4'b0110;  // Ptr back at 0 selects requester 1, not 2
        tick();
        n_vec++; if (bc_input !== 10'b0000011111) begin n_err++;
            $display("FAIL post_reset_grant got %b want 0000011111", bc_input); end
        req = 4'b0000;
        tick(); tick();
        n_vec++; if (ack !== 4'b0010 || result !== 4'd5) begin n_err++;
            $display("FAIL post_reset_ack got ack=%b result=%0d want 0010 5", ack, result); end
        tick();
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        test_reset();
        test_single();
        test_all_requesters();
        test_boundary_words();
        test_wrap();
        test_drop_and_regrant();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
